// File: rtl/mvau_out_collector_if.sv
// Stream bundle between the MVAU, the output collector and the next layer.
// The slave view is the collector. The master view is whoever drives its inputs and consumes its output.
interface mvau_out_collector_if #(
    parameter int PE   = 2,
    parameter int OPE  = 4,
    parameter int TDST = 16
);
    logic                  in_v;
    logic [PE*TDST-1:0]    in_d;
    logic                  in_rdy;
    logic                  out_v;
    logic [OPE*TDST-1:0]   out_d;
    logic                  out_rdy;
    logic                  out_last;

    modport slave (
        input  in_v, in_d, out_rdy,
        output in_rdy, out_v, out_d, out_last
    );

    modport master (
        output in_v, in_d, out_rdy,
        input  in_rdy, out_v, out_d, out_last
    );
endinterface

// File: rtl/mvau_out_collector.sv
// Collects NF PE-wide folds into one MatrixH vector and re-streams it as OPE-wide beats.
// Two ping-pong banks let the next vector fill while the previous one drains.
module mvau_out_collector #(
    parameter int PE   = 2,
    parameter int NF   = 4,
    parameter int OPE  = 4,
    parameter int TDST = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mvau_out_collector_if.slave  bus
);
    localparam int MH   = PE * NF;
    localparam int NO   = MH / OPE;
    localparam int WI_W = (NF > 1) ? $clog2(NF) : 1;
    localparam int RI_W = (NO > 1) ? $clog2(NO) : 1;

    generate
        if ((MH % OPE) != 0) begin : g_bad_ope
            $error("mvau_out_collector: PE*NF must be a multiple of OPE");
        end
    endgenerate

    logic [1:0]            bank_full;
    logic [1:0]            full_nxt;
    logic                  wb;
    logic                  rb;
    logic [WI_W-1:0]       wi;
    logic [RI_W-1:0]       ri;
    logic [MH*TDST-1:0]    bank [2];

    logic accept;
    logic drain;
    logic wi_last;
    logic ri_last;

    assign wi_last = (wi == WI_W'(NF - 1));
    assign ri_last = (ri == RI_W'(NO - 1));

    // in_rdy/out_v depend on registered flags only, so there is no ready-to-ready path.
    assign bus.in_rdy   = ~bank_full[wb];
    assign bus.out_v    = bank_full[rb];
    assign bus.out_last = bank_full[rb] & ri_last;
    assign bus.out_d    = bank[rb][int'(ri)*OPE*TDST +: OPE*TDST];

    assign accept = bus.in_v & ~bank_full[wb];
    assign drain  = bank_full[rb] & bus.out_rdy;

    // wb and rb can only refer to the same bank when it is both empty and full, which cannot happen.
    // A fill completion and a drain completion in the same cycle therefore touch different flags.
    always_comb begin
        full_nxt = bank_full;
        if (accept && wi_last) begin
            full_nxt[wb] = 1'b1;
        end
        if (drain && ri_last) begin
            full_nxt[rb] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= '0;
            wb        <= 1'b0;
            rb        <= 1'b0;
            wi        <= '0;
            ri        <= '0;
            bank[0]   <= '0;
            bank[1]   <= '0;
        end else begin
            bank_full <= full_nxt;
            if (accept) begin
                bank[wb][int'(wi)*PE*TDST +: PE*TDST] <= bus.in_d;
                if (wi_last) begin
                    wb <= ~wb;
                    wi <= '0;
                end else begin
                    wi <= wi + 1'b1;
                end
            end
            if (drain) begin
                if (ri_last) begin
                    rb <= ~rb;
                    ri <= '0;
                end else begin
                    ri <= ri + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mvau_out_collector.sv
// Directed bench for mvau_out_collector: default geometry plus two alternate geometries.
// Element k of vector v is 16*v+k+1.
module tb_mvau_out_collector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mvau_out_collector_if #(.PE(2), .OPE(4), .TDST(16)) if0 ();
    mvau_out_collector_if #(.PE(4), .OPE(2), .TDST(16)) if1 ();
    mvau_out_collector_if #(.PE(2), .OPE(8), .TDST(16)) if2 ();

    mvau_out_collector #(.PE(2), .NF(4), .OPE(4), .TDST(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    mvau_out_collector #(.PE(4), .NF(2), .OPE(2), .TDST(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mvau_out_collector #(.PE(2), .NF(4), .OPE(8), .TDST(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));

    int tests = 0;
    int fails = 0;

    function automatic logic [127:0] elems(input int v, input int start, input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*16 +: 16] = 16'(16*v + start + i + 1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feeds in_nvec vectors into dut0 from vector in_v0 while draining with out_rdy=1.
    // Output beats are checked against vectors starting at out_v0.
    task automatic stream(input int in_v0, input int in_nvec, input int out_v0,
                          input int out_nbeats, output int drops);
        int fi, ob, cyc;
        logic [127:0] t;
        fi = 0; ob = 0; cyc = 0; drops = 0;
        if0.out_rdy = 1'b1;
        while ((fi < in_nvec*4 || ob < out_nbeats) && cyc < 500) begin
            if (fi < in_nvec*4) begin
                t = elems(in_v0 + fi/4, (fi%4)*2, 2);
                if0.in_v = 1'b1;
                if0.in_d = t[31:0];
                if (!if0.in_rdy) drops++;
            end else begin
                if0.in_v = 1'b0;
            end
            if (if0.out_v) begin
                if (ob < out_nbeats) begin
                    t = elems(out_v0 + ob/2, (ob%2)*4, 4);
                    check("stream_out_d", 128'(if0.out_d), t);
                    check("stream_out_last", 128'(if0.out_last), 128'(ob%2 == 1));
                end
                ob++;
            end
            if (if0.in_v && if0.in_rdy) fi++;
            step();
            cyc++;
        end
        if0.in_v = 1'b0;
        check("stream_in_count", 128'(fi), 128'(in_nvec*4));
        check("stream_out_count", 128'(ob), 128'(out_nbeats));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] t;
        int drops;
        if0.in_v = 0; if0.in_d = '0; if0.out_rdy = 0;
        if1.in_v = 0; if1.in_d = '0; if1.out_rdy = 0;
        if2.in_v = 0; if2.in_d = '0; if2.out_rdy = 0;

        // reset state
        #2;
        check("rst_in_rdy", 128'(if0.in_rdy), 128'(1));
        check("rst_out_v", 128'(if0.out_v), 128'(0));
        check("rst_out_last", 128'(if0.out_last), 128'(0));
        check("rst_out_d", 128'(if0.out_d), 128'(0));
        #1 rst_n = 1'b1;
        step();

        // test 1: one vector, out_rdy=1
        if0.out_rdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) check("t1_out_v_before", 128'(if0.out_v), 128'(0));
            t = elems(0, j*2, 2);
            if0.in_v = 1'b1;
            if0.in_d = t[31:0];
            step();
        end
        if0.in_v = 1'b0;
        check("t1_out_v_rise", 128'(if0.out_v), 128'(1));
        check("t1_beat0_d", 128'(if0.out_d), elems(0, 0, 4));
        check("t1_beat0_last", 128'(if0.out_last), 128'(0));
        step();
        check("t1_beat1_v", 128'(if0.out_v), 128'(1));
        check("t1_beat1_d", 128'(if0.out_d), elems(0, 4, 4));
        check("t1_beat1_last", 128'(if0.out_last), 128'(1));
        step();
        check("t1_out_v_fall", 128'(if0.out_v), 128'(0));

        // test 2: backpressure, three vectors offered
        if0.out_rdy = 1'b0;
        for (int b = 0; b < 8; b++) begin
            t = elems(1 + b/4, (b%4)*2, 2);
            if0.in_v = 1'b1;
            if0.in_d = t[31:0];
            check("t2_in_rdy_fill", 128'(if0.in_rdy), 128'(1));
            step();
        end
        t = elems(3, 0, 2);
        if0.in_d = t[31:0];
        for (int c = 0; c < 3; c++) begin
            check("t2_in_rdy_full", 128'(if0.in_rdy), 128'(0));
            check("t2_hold_d", 128'(if0.out_d), elems(1, 0, 4));
            check("t2_hold_last", 128'(if0.out_last), 128'(0));
            step();
        end
        stream(3, 1, 1, 6, drops);
        check("t2_out_v_idle", 128'(if0.out_v), 128'(0));

        // test 3: continuous full rate
        stream(4, 10, 4, 20, drops);
        check("t3_in_rdy_drops", 128'(drops), 128'(0));
        check("t3_out_v_idle", 128'(if0.out_v), 128'(0));

        // test 4a: PE=4, NF=2, OPE=2
        if1.out_rdy = 1'b1;
        for (int j = 0; j < 2; j++) begin
            t = elems(0, j*4, 4);
            if1.in_v = 1'b1;
            if1.in_d = t[63:0];
            step();
        end
        if1.in_v = 1'b0;
        for (int b = 0; b < 4; b++) begin
            t = elems(0, b*2, 2);
            check("t4a_out_v", 128'(if1.out_v), 128'(1));
            check("t4a_out_d", 128'(if1.out_d), 128'(t[31:0]));
            check("t4a_out_last", 128'(if1.out_last), 128'(b == 3));
            step();
        end
        check("t4a_out_v_idle", 128'(if1.out_v), 128'(0));

        // test 4b: PE=2, NF=4, OPE=8, every beat is last
        if2.out_rdy = 1'b0;
        for (int b = 0; b < 8; b++) begin
            t = elems(b/4, (b%4)*2, 2);
            if2.in_v = 1'b1;
            if2.in_d = t[31:0];
            step();
        end
        if2.in_v = 1'b0;
        if2.out_rdy = 1'b1;
        for (int b = 0; b < 2; b++) begin
            check("t4b_out_v", 128'(if2.out_v), 128'(1));
            check("t4b_out_d", 128'(if2.out_d), elems(b, 0, 8));
            check("t4b_out_last", 128'(if2.out_last), 128'(1));
            step();
        end
        check("t4b_out_v_idle", 128'(if2.out_v), 128'(0));

        // test 5: async reset with one full bank and a partial one
        if0.out_rdy = 1'b0;
        for (int b = 0; b < 6; b++) begin
            t = elems(20 + b/4, (b%4)*2, 2);
            if0.in_v = 1'b1;
            if0.in_d = t[31:0];
            step();
        end
        if0.in_v = 1'b0;
        check("t5_pre_out_v", 128'(if0.out_v), 128'(1));
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_out_v", 128'(if0.out_v), 128'(0));
        check("t5_rst_in_rdy", 128'(if0.in_rdy), 128'(1));
        check("t5_rst_out_d", 128'(if0.out_d), 128'(0));
        check("t5_rst_out_last", 128'(if0.out_last), 128'(0));
        #2 rst_n = 1'b1;
        step();
        stream(22, 1, 22, 2, drops);
        check("t5_out_v_idle", 128'(if0.out_v), 128'(0));

        // test 6: in_v with corrupt data while full must be ignored
        if0.out_rdy = 1'b0;
        for (int b = 0; b < 8; b++) begin
            t = elems(23 + b/4, (b%4)*2, 2);
            if0.in_v = 1'b1;
            if0.in_d = t[31:0];
            step();
        end
        if0.in_d = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            check("t6_in_rdy_full", 128'(if0.in_rdy), 128'(0));
            step();
        end
        if0.in_v = 1'b0;
        stream(25, 1, 23, 6, drops);
        check("t6_out_v_idle", 128'(if0.out_v), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
